// File: rtl/if_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_if
// Purpose  : Instruction-memory request/response bus between the fetch
//            stage (master) and the instruction memory (slave).
// Signals  : ireq_valid  - request valid (master -> slave)
//            ireq_addr   - 64-bit request address (master -> slave)
//            ireq_ready  - request accepted when valid && ready (slave -> master)
//            iresp_valid - one-cycle response pulse (slave -> master)
//            iresp_data  - 32-bit instruction word (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface if_fetch_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  ireq_ready,
    input  iresp_valid,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output ireq_ready,
    output iresp_valid,
    output iresp_data
  );
endinterface
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Purpose  : Single-outstanding-request instruction fetch stage. Issues a
//            request at the current fetch PC, waits for the response, holds
//            the instruction until decode accepts it, then advances PC by 4.
//            A pipeline flush redirects the fetch PC and drains any response
//            still in flight.
// Ports    : clk            - clock, rising edge
//            reset          - synchronous active-high reset (overrides all)
//            block          - decode stall while an instruction is held
//            pipeline_flush - discard in-flight/held fetch, restart at redirect
//            redirect_pc    - restart address (low two bits forced to zero)
//            mem            - instruction memory bus (master side)
//            pc_out         - PC of the held instruction
//            instr_out      - held instruction word
//            if_finish      - pc_out/instr_out valid; transfer when !block
// Params   : RESET_PC       - first fetch address after reset, word aligned
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              block,
  input  logic              pipeline_flush,
  input  logic [63:0]       redirect_pc,
  if_fetch_if.master        mem,
  output logic [63:0]       pc_out,
  output logic [31:0]       instr_out,
  output logic              if_finish
);

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [63:0] r_fetch_pc;
  logic [63:0] w_fetch_pc_next;
  logic [63:0] r_pc_out;
  logic [31:0] r_instr_out;
  logic        w_capture;
  logic [63:0] w_redirect_aligned;

  assign w_redirect_aligned = redirect_pc & ~64'h3;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= REQ;
      r_fetch_pc  <= RESET_PC;
      r_pc_out    <= 64'd0;
      r_instr_out <= 32'd0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      if (w_capture) begin
        r_pc_out    <= r_fetch_pc;
        r_instr_out <= mem.iresp_data;
      end
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_capture       = 1'b0;

    case (r_state)
      REQ: begin
        // An accepted request under flush still has a response coming back,
        // so it must be drained before a new request may go out.
        if (mem.ireq_ready) begin
          w_state_next = pipeline_flush ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (mem.iresp_valid) begin
          if (pipeline_flush) begin
            w_state_next = REQ;
          end else begin
            w_state_next = HOLD;
            w_capture    = 1'b1;
          end
        end else if (pipeline_flush) begin
          w_state_next = DRAIN;
        end
      end
      HOLD: begin
        if (pipeline_flush) begin
          w_state_next = REQ;
        end else if (!block) begin
          w_state_next    = REQ;
          w_fetch_pc_next = r_fetch_pc + 64'd4;
        end
      end
      DRAIN: begin
        if (mem.iresp_valid) begin
          w_state_next = REQ;
        end
      end
      default: begin
        w_state_next = REQ;
      end
    endcase

    // Flush takes priority over the +4 advance of a same-cycle transfer.
    if (pipeline_flush) begin
      w_fetch_pc_next = w_redirect_aligned;
    end
  end

  // Request valid is gated by reset so nothing is issued during the reset cycle.
  assign mem.ireq_valid = (r_state == REQ) && !reset;
  assign mem.ireq_addr  = r_fetch_pc;
  assign if_finish      = (r_state == HOLD);
  assign pc_out         = r_pc_out;
  assign instr_out      = r_instr_out;

endmodule
`default_nettype wire
